// File: rtl/branch_resolve_ctrl_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl_if
//   Bundles the fetch lookup, the EX-stage branch resolution inputs and the
//   redirect/flush outputs exchanged between the pipeline and the branch
//   resolution controller.
//
//   master : pipeline side (drives fetch PC, stall and EX fields,
//            receives prediction, redirect and flush)
//   slave  : branch_resolve_ctrl side
//
//   Signals
//     if_pc          fetch PC used for the prediction lookup
//     pred_taken     prediction for if_pc (combinational)
//     stall          pipeline stall
//     ex_valid       EX stage holds a valid instruction
//     ex_is_br       EX instruction is a conditional branch or JAL/JALR
//     ex_is_cond     EX instruction is a conditional branch
//     ex_pred_taken  prediction carried with the EX instruction
//     branch_out     resolved outcome
//     ex_pc          PC of the EX instruction
//     ex_target      computed branch/jump target
//     redirect_valid one-cycle redirect strobe
//     redirect_pc    corrected fetch PC
//     flush          squash IF/ID and ID/EX
// ----------------------------------------------------------------------------
interface branch_resolve_ctrl_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_br;
  logic        ex_is_cond;
  logic        ex_pred_taken;
  logic        branch_out;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  modport master (
    output if_pc, stall, ex_valid, ex_is_br, ex_is_cond, ex_pred_taken,
           branch_out, ex_pc, ex_target,
    input  pred_taken, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  if_pc, stall, ex_valid, ex_is_br, ex_is_cond, ex_pred_taken,
           branch_out, ex_pc, ex_target,
    output pred_taken, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl
//   Resolves branches in EX: detects mispredicts, issues a one-cycle PC
//   redirect followed by a FLUSH_CYCLES-long pipeline flush, and (optionally)
//   maintains a table of 2-bit saturating predictor counters looked up by the
//   fetch PC.
//
//   Optional feature macro: BRANCH_PRED_EN
//     defined   -> dynamic predictor table indexed by PC[log2(BHT_ENTRIES)+1:2]
//     undefined -> pred_taken tied to 0, no table storage
//
//   Parameters
//     BHT_ENTRIES   number of 2-bit counters (power of two, 4..256)
//     FLUSH_CYCLES  total cycles flush is held per redirect (1..4)
//
//   Ports
//     clk    single clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    branch_resolve_ctrl_if.slave (fetch lookup, EX resolution,
//            redirect_valid / redirect_pc / flush outputs)
// ----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  // Remaining DRAIN cycles minus one, loaded when leaving REDIRECT.
  localparam logic [1:0] DRAIN_INIT = 2'(FLUSH_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t      state_reg;
  logic [1:0]  drain_cnt_reg;
  logic        redirect_valid_reg;
  logic        flush_reg;
  logic [31:0] redirect_pc_reg;

  // EX inputs are only looked at in IDLE on a non-stalled cycle.
  logic        accept;
  logic        mispredict;
  logic [31:0] fix_pc;

  assign accept     = !bus.stall && (state_reg == IDLE) && bus.ex_valid;
  assign mispredict = accept && bus.ex_is_br &&
                      (bus.branch_out != bus.ex_pred_taken);
  assign fix_pc     = bus.branch_out ? bus.ex_target : (bus.ex_pc + 32'd4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg          <= IDLE;
      drain_cnt_reg      <= 2'd0;
      redirect_valid_reg <= 1'b0;
      flush_reg          <= 1'b0;
      redirect_pc_reg    <= 32'd0;
    end else if (!bus.stall) begin
      case (state_reg)
        IDLE: begin
          if (mispredict) begin
            state_reg          <= REDIRECT;
            redirect_pc_reg    <= fix_pc;
            redirect_valid_reg <= 1'b1;
            flush_reg          <= 1'b1;
          end
        end
        REDIRECT: begin
          redirect_valid_reg <= 1'b0;
          if (FLUSH_CYCLES == 1) begin
            state_reg <= IDLE;
            flush_reg <= 1'b0;
          end else begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == 2'd0) begin
            state_reg <= IDLE;
            flush_reg <= 1'b0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - 2'd1;
          end
        end
        default: begin
          state_reg          <= IDLE;
          redirect_valid_reg <= 1'b0;
          flush_reg          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_pc    = redirect_pc_reg;
  assign bus.flush          = flush_reg;

`ifdef BRANCH_PRED_EN
  // Only conditional branches train the table.
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic [BHT_ENTRIES-1:0] ctr_msb;

  assign upd_en  = accept && bus.ex_is_cond;
  assign upd_idx = bus.ex_pc[IDX_W+1:2];

  for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
    logic [1:0] ctr_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ctr_reg <= 2'b01;
      end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
        if (bus.branch_out) begin
          if (ctr_reg != 2'b11) ctr_reg <= ctr_reg + 2'd1;
        end else begin
          if (ctr_reg != 2'b00) ctr_reg <= ctr_reg - 2'd1;
        end
      end
    end

    assign ctr_msb[gi] = ctr_reg[1];
  end

  // Lookup reads the flops directly, so a same-cycle update is not visible
  // until after the edge.
  assign bus.pred_taken = ctr_msb[bus.if_pc[IDX_W+1:2]];
`else
  assign bus.pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Self-checking bench for branch_resolve_ctrl: directed scenarios followed
//   by randomized traffic, all compared against a cycle-count reference model
//   (flush cycles remaining + array of integer counters).
// ----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  localparam int BHT = 16;
  localparam int FC  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  branch_resolve_ctrl_if bus ();

  branch_resolve_ctrl #(
    .BHT_ENTRIES (BHT),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          bht_m [BHT];
  int          busy_left;   // flush cycles still to show, including current
  bit          first_m;     // current cycle is the redirect cycle
  logic [31:0] rpc_m;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'(BHT - 1));
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_PRED_EN
    return (bht_m[idx_of(pc)] >= 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    busy_left = 0;
    first_m   = 1'b0;
    rpc_m     = 32'd0;
    for (int i = 0; i < BHT; i++) bht_m[i] = 1;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    if (bus.stall) return;
    if (busy_left == 0) begin
      if (bus.ex_valid) begin
        if (bus.ex_is_br && (bus.branch_out != bus.ex_pred_taken)) begin
          busy_left = FC;
          first_m   = 1'b1;
          rpc_m     = bus.branch_out ? bus.ex_target : bus.ex_pc + 32'd4;
        end
        if (bus.ex_is_cond) begin
          int k;
          k = idx_of(bus.ex_pc);
          if (bus.branch_out) bht_m[k] = (bht_m[k] < 3) ? bht_m[k] + 1 : 3;
          else                bht_m[k] = (bht_m[k] > 0) ? bht_m[k] - 1 : 0;
        end
      end
    end else begin
      busy_left--;
      first_m = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_val("flush",          32'(bus.flush),          32'(busy_left > 0));
    check_val("redirect_valid", 32'(bus.redirect_valid), 32'(first_m));
    check_val("redirect_pc",    bus.redirect_pc,         rpc_m);
    check_val("pred_taken",     32'(bus.pred_taken),     32'(model_pred(bus.if_pc)));
  endtask

  // Inputs are driven just before calling; checks the pre-edge lookup, then
  // the post-edge outputs.
  task automatic step();
    #1;
    check_val("pred_pre", 32'(bus.pred_taken), 32'(model_pred(bus.if_pc)));
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_ex(input logic v, input logic br, input logic cond,
                        input logic ep, input logic bo,
                        input logic [31:0] pc, input logic [31:0] tgt);
    bus.ex_valid      = v;
    bus.ex_is_br      = br;
    bus.ex_is_cond    = cond;
    bus.ex_pred_taken = ep;
    bus.branch_out    = bo;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
  endtask

  task automatic clear_ex();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_flush", 32'(bus.flush),          32'd0);
    check_val("rst_rv",    32'(bus.redirect_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.stall = 1'b0;
    clear_ex();
  endtask

  initial begin
    bus.if_pc = 32'd0;
    bus.stall = 1'b0;
    clear_ex();
    model_reset();
    do_reset();

    // After reset: weakly not-taken, no flush, no redirect
    bus.if_pc = 32'h100;
    #1;
    check_val("init_pred",  32'(bus.pred_taken),     32'd0);
    check_val("init_flush", 32'(bus.flush),          32'd0);
    check_val("init_rv",    32'(bus.redirect_valid), 32'd0);
    $display("txn reset: if_pc=0x100 pred=%0d flush=%0d rv=%0d",
             bus.pred_taken, bus.flush, bus.redirect_valid);

    // Taken BEQ mispredicted not-taken -> redirect to target, flush 2 cycles
    set_ex(1, 1, 1, 0, 1, 32'h200, 32'h240);
    step();
    check_val("beq_rv",  32'(bus.redirect_valid), 32'd1);
    check_val("beq_rpc", bus.redirect_pc,         32'h240);
    check_val("beq_fl1", 32'(bus.flush),          32'd1);
    clear_ex();
    step();
    check_val("beq_fl2", 32'(bus.flush),          32'd1);
    check_val("beq_rv2", 32'(bus.redirect_valid), 32'd0);
    step();
    check_val("beq_fl3", 32'(bus.flush),          32'd0);
    $display("txn beq: pc=0x200 target=0x240 redirect_pc=0x%0h", bus.redirect_pc);

    // Not-taken BNE mispredicted taken -> fall-through, counter 01 -> 00
    do_reset();
    bus.if_pc = 32'h300;
    set_ex(1, 1, 1, 1, 0, 32'h300, 32'h999);
    step();
    check_val("bne_rpc", bus.redirect_pc, 32'h304);
    clear_ex();
    step();
    step();
    // one taken update: 00 -> 01 keeps pred 0 (01 -> 10 would not)
    set_ex(1, 1, 1, 1, 1, 32'h300, 32'h999);
    step();
    clear_ex();
    step();
    check_val("bne_pred", 32'(bus.pred_taken), 32'd0);
    $display("txn bne: pc=0x300 redirect_pc=0x%0h", bus.redirect_pc);

    // Same PC taken four times -> saturate at 11
    do_reset();
    bus.if_pc = 32'h340;
    for (int i = 0; i < 4; i++) begin
      set_ex(1, 1, 1, 1, 1, 32'h340, 32'h400);
      step();
`ifdef BRANCH_PRED_EN
      if (i == 1) check_val("sat_pred2", 32'(bus.pred_taken), 32'd1);
`endif
    end
    // one not-taken update: 11 -> 10 stays predicted taken
    set_ex(1, 1, 1, 0, 0, 32'h340, 32'h400);
    step();
    clear_ex();
    step();
    $display("txn sat: pc=0x340 pred=%0d", bus.pred_taken);

    // Mispredict during DRAIN is ignored
    do_reset();
    set_ex(1, 1, 0, 0, 1, 32'h500, 32'h800);
    step();
    set_ex(1, 1, 1, 0, 1, 32'h600, 32'h900);
    step();
    step();
    check_val("drain_ign_fl",  32'(bus.flush),          32'd0);
    check_val("drain_ign_rpc", bus.redirect_pc,         32'h800);
    clear_ex();
    step();
    // Stall during REDIRECT stretches redirect_valid
    set_ex(1, 1, 0, 0, 1, 32'h700, 32'ha00);
    step();
    clear_ex();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_rv", 32'(bus.redirect_valid), 32'd1);
    end
    bus.stall = 1'b0;
    step();
    check_val("unstall_rv", 32'(bus.redirect_valid), 32'd0);
    step();
    $display("txn stall: redirect_pc=0x%0h held across stall", bus.redirect_pc);

    // Reset asserted during DRAIN drops flush immediately
    set_ex(1, 1, 1, 0, 1, 32'h200, 32'h280);
    step();
    clear_ex();
    step();
    check_val("pre_rst_fl", 32'(bus.flush), 32'd1);
    do_reset();
    bus.if_pc = 32'h200;
    step();
    check_val("post_rst_pred", 32'(bus.pred_taken), 32'd0);
    check_val("post_rst_fl",   32'(bus.flush),      32'd0);
    $display("txn reset_in_drain: flush=%0d pred=%0d", bus.flush, bus.pred_taken);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic br;
      if ($urandom_range(0, 599) == 0) do_reset();
      br = 1'($urandom_range(0, 1));
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.if_pc = 32'($urandom_range(0, 63)) << 2;
      set_ex(1'($urandom_range(0, 1)), br, br & 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC
                                          : (32'($urandom_range(0, 63)) << 2),
             $urandom());
      step();
    end
    $display("txn random: 3000 cycles done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
